// File: rtl/alu_defs.sv
// Shared definitions for the ALU issue unit: ALU control codes, opcode/funct
// encodings, FSM states and the instruction decoder.
package alu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_SLTI  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;

    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       illegal;
        logic       use_imm;
        logic       is_beq;
        logic       writes;
        logic       dest_rd;
    } decode_t;

    // Illegal encodings never write back, so the WB stage only needs 'writes'.
    function automatic decode_t decode_instr(input logic [3:0] opcode, input logic [5:0] funct);
        decode_t d;
        d.alu_op  = ALU_ADD;
        d.illegal = 1'b0;
        d.use_imm = 1'b1;
        d.is_beq  = 1'b0;
        d.writes  = 1'b1;
        d.dest_rd = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                d.use_imm = 1'b0;
                d.dest_rd = 1'b1;
                case (funct)
                    F_AND:   d.alu_op = ALU_AND;
                    F_OR:    d.alu_op = ALU_OR;
                    F_ADD:   d.alu_op = ALU_ADD;
                    F_SUB:   d.alu_op = ALU_SUB;
                    F_SLT:   d.alu_op = ALU_SLT;
                    default: begin
                        d.illegal = 1'b1;
                        d.writes  = 1'b0;
                    end
                endcase
            end
            OP_ADDI: d.alu_op = ALU_ADD;
            OP_ANDI: d.alu_op = ALU_AND;
            OP_ORI:  d.alu_op = ALU_OR;
            OP_SLTI: d.alu_op = ALU_SLT;
            OP_BEQ: begin
                d.alu_op  = ALU_SUB;
                d.use_imm = 1'b0;
                d.is_beq  = 1'b1;
                d.writes  = 1'b0;
            end
            default: begin
                d.illegal = 1'b1;
                d.writes  = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 4-entry register file: one synchronous write port, two combinational read
// ports and a debug read port. Register 0 always reads as zero.
module alu_issue_regfile #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [1:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [1:0]       raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [1:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [1:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    logic [WIDTH-1:0] regs_q [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 2'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = (raddr_a_i  == 2'd0) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o  = (raddr_b_i  == 2'd0) ? '0 : regs_q[raddr_b_i];
    assign dbg_data_o = (dbg_addr_i == 2'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue unit: accepts an instruction, reads operands, drives an
// external combinational ALU for one cycle and writes the result back.
module alu_issue_ctrl
    import alu_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [15:0]      instr,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             done,
    output logic             taken,
    output logic             illegal,
    input  logic [1:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    state_e           state_q, state_d;
    logic [15:0]      instr_q;
    decode_t          dec_q, dec_d;
    logic [2:0]       alu_op_q;
    logic [WIDTH-1:0] alu_a_q, alu_b_q, res_q;
    logic             taken_q, illegal_q;

    logic [WIDTH-1:0] rdata_a, rdata_b, opb;
    logic             wb_we;
    logic [1:0]       wb_addr;

    assign dec_d   = decode_instr(instr_q[15:12], instr_q[5:0]);
    assign opb     = dec_d.use_imm ? WIDTH'($signed(instr_q[3:0])) : rdata_b;
    assign wb_we   = (state_q == ST_WB) && dec_q.writes;
    assign wb_addr = dec_q.dest_rd ? instr_q[7:6] : instr_q[9:8];

    alu_issue_regfile #(.WIDTH(WIDTH)) u_regfile (
        .clk        (clk),
        .reset      (reset),
        .we_i       (wb_we),
        .waddr_i    (wb_addr),
        .wdata_i    (res_q),
        .raddr_a_i  (instr_q[11:10]),
        .rdata_a_o  (rdata_a),
        .raddr_b_i  (instr_q[9:8]),
        .rdata_b_o  (rdata_b),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (instr_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU operands are loaded on leaving READ so they are stable for all of EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            dec_q     <= '0;
            alu_op_q  <= ALU_AND;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            res_q     <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (instr_valid) instr_q <= instr;
                ST_READ: begin
                    dec_q    <= dec_d;
                    alu_op_q <= dec_d.alu_op;
                    alu_a_q  <= rdata_a;
                    alu_b_q  <= opb;
                end
                ST_EXEC: begin
                    res_q     <= alu_result;
                    taken_q   <= dec_q.is_beq && !dec_q.illegal && alu_zero;
                    illegal_q <= dec_q.illegal;
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign done        = (state_q == ST_WB);
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign taken       = taken_q;
    assign illegal     = illegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle issue/control unit that drives the op/a/b side of the combinational MIPS-style ALU and consumes its result/zero outputs. It accepts 16-bit mini-MIPS instruction words over a valid/ready handshake and decodes opcode/funct into the 3-bit ALU control code. It reads operands from an internal 4-entry register file, issues them to the ALU and writes the result back. Branch-compare instructions report taken/not-taken from the ALU zero flag.

Parameters:
WIDTH, 4, datapath and register width in bits (>= 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid  input  1  instruction word present
instr_ready  output  1  unit can accept; high only in IDLE
instr  input  16  [15:12] opcode, [11:10] rs, [9:8] rt, [7:6] rd, [5:0] funct; imm4 = [3:0]
alu_op  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
alu_a  output  WIDTH  ALU operand A
alu_b  output  WIDTH  ALU operand B
alu_result  input  WIDTH  ALU result (combinational)
alu_zero  input  1  ALU zero flag
done  output  1  one-cycle pulse when an instruction retires
taken  output  1  valid with done: BEQ compared equal
illegal  output  1  valid with done: undecodable instruction
dbg_addr  input  2  register-file debug read address
dbg_data  output  WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async, any state): FSM to IDLE. reg[0..3]=0, alu_op=000, alu_a=alu_b=0, done=taken=illegal=0. instr_ready=1 after reset deasserts.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE. No stalls.
- IDLE: instr_ready=1. On instr_valid=1, latch instr and go to READ. instr_valid=0: stay.
- READ: latch opA=reg[rs] and opB, where opB=reg[rt] for R-type/BEQ and sign_extend(imm4, WIDTH) for I-type. Decode alu_op. Unknown opcode/funct sets the internal illegal flag.
- EXEC: drive alu_op/alu_a/alu_b from registers for the whole cycle. At the end of the cycle, capture alu_result and alu_zero.
- WB: done=1 for exactly this cycle. Write the captured result to the destination, unless illegal or BEQ. Destination is rd for R-type and rt for I-type. taken=alu_zero capture for BEQ and 0 otherwise. illegal as decoded.
- taken and illegal hold their values until the next done. alu_* outputs hold their last values outside EXEC.
- Latency: accept at cycle N, done at N+3, next accept no earlier than N+4.
- Decode:
  - opcode 0000 is R-type. funct 100100 AND, 100101 OR, 100000 ADD, 100010 SUB, 101010 SLT; any other funct is illegal.
  - 0001 ADDI (010), 0010 ANDI (000), 0011 ORI (001), 0100 SLTI (111), 0101 BEQ (110, no write).
  - 0110–1111 are illegal.
- Register 0 is hardwired zero: writes are discarded and reads return 0.
- Arithmetic is the ALU's. Results wrap modulo 2^WIDTH. No overflow flag.
- Illegal instruction: no register write, no ALU side-effect requirement; done=1, illegal=1, taken=0.
- instr changing while not in IDLE is ignored.
- dbg_data reflects a write from the cycle after WB.

Decomposition:
- Shared package/header alu_defs: ALU op codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), opcode constants, funct constants, FSM state encodings.
- The ALU test bench reuses the op-code constants.
- One natural sub-module: alu_issue_regfile. It has 4xWIDTH registers, one synchronous write port, two combinational read ports and a debug read port, with reg0 forced to zero.

Test Plan:
1. Reset mid-EXEC of ADDI r1,r0,7 -> outputs 0, no done, reg1 stays 0000, instr_ready=1 after release.
2. ADDI r1,r0,7; ADDI r2,r0,1; AND r3,r1,r2 -> dbg r1=0111, r2=0001, r3=0001. Each done pulse lands exactly 3 cycles after acceptance, with instr_ready low in between.
3. ADD r3,r1,r2 -> r3=1000 (wrap at WIDTH=4). SUB r3,r1,r1 -> r3=0000, with alu_op=110 seen in EXEC.
4. ADDI r2,r0,-2 (imm 1110); ADDI r1,r0,-1; SLT r3,r2,r1 -> r3=0001. SLTI r3,r1,5 -> r3=0001.
5. BEQ r1,r1 -> done=1, taken=1, no register changes. BEQ r1,r2 with r1=0111, r2=0001 -> taken=0.
6. Opcode 1111, then R-type funct 000000, then ADDI r0,r0,5 -> first two give illegal=1 with no writes; third gives illegal=0 and r0 still reads 0000.
